// File: rtl/row_event_readout.sv
// rtl/row_event_readout.sv - row event latch, arbiter handshake sequencer and packet emitter
module row_event_readout #(
  parameter int LVL_ROWS    = 2,
  parameter int LVL_ROW_ADD = 1,
  parameter int TS_WIDTH    = 16
) (
  input  logic                              clk_i,
  input  logic                              reset_i,
  input  logic                              en_i,
  input  logic [LVL_ROWS-1:0]               event_i,
  input  logic [LVL_ROWS-1:0]               pol_i,
  output logic [LVL_ROWS-1:0]               req_o,
  output logic                              arb_enable_o,
  output logic                              arb_refresh_o,
  input  logic [LVL_ROWS-1:0]               gnt_i,
  input  logic [LVL_ROW_ADD-1:0]            xadd_i,
  input  logic                              grp_release_i,
  output logic                              evt_valid_o,
  input  logic                              evt_ready_i,
  output logic [TS_WIDTH+LVL_ROW_ADD:0]     evt_data_o,
  output logic [7:0]                        drop_cnt_o
);

  localparam int DW = TS_WIDTH + LVL_ROW_ADD + 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_GRANT   = 3'd1,
    S_CAPTURE = 3'd2,
    S_SEND    = 3'd3,
    S_REFRESH = 3'd4
  } state_e;

  state_e                state_q, state_d;
  logic [TS_WIDTH-1:0]   ts_q, ts_d;
  logic [LVL_ROWS-1:0]   pend_q, pend_d;
  logic [LVL_ROWS-1:0]   pol_q, pol_d;
  logic [DW-1:0]         data_q, data_d;
  logic [7:0]            drop_q, drop_d;

  logic                  capture_hit;
  logic [LVL_ROWS-1:0]   clr;
  logic [LVL_ROWS-1:0]   drop;
  logic                  pol_sel;
  logic [15:0]           drop_sum;

  // Pending/polarity update: a clear from CAPTURE loses to a same-cycle event,
  // and an event on a still-pending row is dropped without touching polarity.
  always_comb begin
    capture_hit = (state_q == S_CAPTURE) && (|gnt_i);
    clr         = '0;
    drop        = '0;
    pend_d      = pend_q;
    pol_d       = pol_q;
    pol_sel     = 1'b0;
    drop_sum    = {8'd0, drop_q};
    for (int r = 0; r < LVL_ROWS; r++) begin
      clr[r]    = capture_hit && (xadd_i == LVL_ROW_ADD'(r));
      drop[r]   = event_i[r] && pend_q[r] && !clr[r];
      pend_d[r] = (pend_q[r] && !clr[r]) || event_i[r];
      if (event_i[r] && !drop[r]) begin
        pol_d[r] = pol_i[r];
      end
      if (xadd_i == LVL_ROW_ADD'(r)) begin
        pol_sel = pol_q[r];
      end
      drop_sum = drop_sum + 16'(drop[r]);
    end
    drop_d = (drop_sum > 16'd255) ? 8'hFF : drop_sum[7:0];
    ts_d   = ts_q + 1'b1;
    data_d = capture_hit ? {ts_q, xadd_i, pol_sel} : data_q;
  end

  // State and datapath registers, asynchronously cleared.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      ts_q    <= '0;
      pend_q  <= '0;
      pol_q   <= '0;
      data_q  <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      ts_q    <= ts_d;
      pend_q  <= pend_d;
      pol_q   <= pol_d;
      data_q  <= data_d;
      drop_q  <= drop_d;
    end
  end

  // Next-state sequencing of one grant cycle; en_i only gates leaving IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (en_i && (|pend_q)) state_d = S_GRANT;
      S_GRANT:   state_d = S_CAPTURE;
      S_CAPTURE: state_d = (|gnt_i) ? S_SEND : S_REFRESH;
      S_SEND:    if (evt_ready_i) state_d = grp_release_i ? S_REFRESH : S_IDLE;
      S_REFRESH: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from state only; enable and refresh come from distinct states.
  always_comb begin
    arb_enable_o  = (state_q == S_GRANT);
    arb_refresh_o = (state_q == S_REFRESH);
    evt_valid_o   = (state_q == S_SEND);
    req_o         = pend_q;
    evt_data_o    = data_q;
    drop_cnt_o    = drop_q;
  end

endmodule

// File: tb/tb_row_event_readout.sv
// tb/tb_row_event_readout.sv - directed bench for row_event_readout
module tb_row_event_readout;

  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic        en_i = 1'b1;
  logic [1:0]  event_i = 2'b00;
  logic [1:0]  pol_i = 2'b00;
  logic [1:0]  req_o;
  logic        arb_enable_o;
  logic        arb_refresh_o;
  logic [1:0]  gnt_i;
  logic [0:0]  xadd_i;
  logic        grp_release_i;
  logic        evt_valid_o;
  logic        evt_ready_i = 1'b1;
  logic [17:0] evt_data_o;
  logic [7:0]  drop_cnt_o;

  row_event_readout #(.LVL_ROWS(2), .LVL_ROW_ADD(1), .TS_WIDTH(16)) dut (
    .clk_i(clk), .reset_i(reset_i), .en_i(en_i), .event_i(event_i), .pol_i(pol_i),
    .req_o(req_o), .arb_enable_o(arb_enable_o), .arb_refresh_o(arb_refresh_o),
    .gnt_i(gnt_i), .xadd_i(xadd_i), .grp_release_i(grp_release_i),
    .evt_valid_o(evt_valid_o), .evt_ready_i(evt_ready_i), .evt_data_o(evt_data_o),
    .drop_cnt_o(drop_cnt_o)
  );

  always #5 clk = ~clk;

  // Behavioural arbiter: registered lowest-unmasked grant, mask cleared on refresh.
  logic [1:0] a_gnt, a_mask, elig;
  logic       a_add;
  assign elig          = req_o & ~a_mask;
  assign grp_release_i = (elig == 2'b00);
  assign gnt_i         = a_gnt;
  assign xadd_i        = a_add;
  always @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      a_gnt <= 2'b00; a_add <= 1'b0; a_mask <= 2'b00;
    end else if (arb_refresh_o) begin
      a_mask <= 2'b00;
    end else if (arb_enable_o) begin
      if (elig[0]) begin a_gnt <= 2'b01; a_add <= 1'b0; a_mask <= a_mask | 2'b01; end
      else if (elig[1]) begin a_gnt <= 2'b10; a_add <= 1'b1; a_mask <= a_mask | 2'b10; end
      else a_gnt <= 2'b00;
    end
  end

  // Cycle index since reset release; equals the expected timestamp.
  int cyc;
  always @(posedge clk or posedge reset_i) begin
    if (reset_i) cyc <= 0;
    else cyc <= cyc + 1;
  end

  int total = 0;
  int bad = 0;
  logic [17:0] pkts[$];
  int nref;
  int nref_late;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic pulse(input logic [1:0] ev, input logic [1:0] pol);
    event_i = ev; pol_i = pol;
    @(negedge clk);
    event_i = 2'b00; pol_i = 2'b00;
  endtask

  task automatic run_collect(input int n);
    for (int i = 0; i < n; i++) begin
      if (evt_valid_o && evt_ready_i) pkts.push_back(evt_data_o);
      if (arb_refresh_o) begin
        nref++;
        if (pkts.size() >= 2) nref_late++;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_valid(input string name);
    int k = 0;
    while (!evt_valid_o && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk(name, 32'(evt_valid_o), 32'd1);
  endtask

  typedef struct {
    logic [1:0]  ev;
    logic [1:0]  pol;
    logic        rdy;
    logic [1:0]  req;
    logic        en;
    logic        rf;
    logic        vld;
    logic        chk_d;
    logic [17:0] data;
  } vec_t;

  vec_t vt[7];
  int   t0;
  logic [17:0] held;
  int   nen;

  initial begin
    //            ev     pol    rdy   req    en    rf    vld   chkd  data
    vt[0] = '{2'b10, 2'b10, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 18'h0};
    vt[1] = '{2'b00, 2'b00, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 18'h0};
    vt[2] = '{2'b00, 2'b00, 1'b1, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 18'h0};
    vt[3] = '{2'b00, 2'b00, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 18'h0};
    vt[4] = '{2'b00, 2'b00, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, {16'd3, 1'b1, 1'b1}};
    vt[5] = '{2'b00, 2'b00, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 18'h0};
    vt[6] = '{2'b00, 2'b00, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 18'h0};

    repeat (3) @(negedge clk);
    reset_i = 1'b0;

    // Single event on row 1 straight out of reset, cycle by cycle.
    for (int i = 0; i < 7; i++) begin
      event_i = vt[i].ev; pol_i = vt[i].pol; evt_ready_i = vt[i].rdy;
      chk($sformatf("t1_req_c%0d", i), 32'(req_o), 32'(vt[i].req));
      chk($sformatf("t1_en_c%0d", i), 32'(arb_enable_o), 32'(vt[i].en));
      chk($sformatf("t1_ref_c%0d", i), 32'(arb_refresh_o), 32'(vt[i].rf));
      chk($sformatf("t1_vld_c%0d", i), 32'(evt_valid_o), 32'(vt[i].vld));
      chk($sformatf("t1_drop_c%0d", i), 32'(drop_cnt_o), 32'd0);
      if (vt[i].chk_d) chk($sformatf("t1_data_c%0d", i), 32'(evt_data_o), 32'(vt[i].data));
      @(negedge clk);
    end
    event_i = 2'b00; pol_i = 2'b00;

    // Both rows at once: row 0 then row 1, one refresh after the second packet.
    pkts.delete(); nref = 0; nref_late = 0;
    t0 = cyc;
    pulse(2'b11, 2'b01);
    run_collect(14);
    chk("t2_npkts", 32'(pkts.size()), 32'd2);
    if (pkts.size() == 2) begin
      chk("t2_p0", 32'(pkts[0]), 32'({16'(t0 + 3), 1'b0, 1'b1}));
      chk("t2_p1", 32'(pkts[1]), 32'({16'(t0 + 7), 1'b1, 1'b0}));
    end
    chk("t2_nref", 32'(nref), 32'd1);
    chk("t2_nref_late", 32'(nref_late), 32'd1);

    // Backpressure: valid and data hold for 10 cycles, accept on cycle 11.
    evt_ready_i = 1'b0;
    t0 = cyc;
    pulse(2'b01, 2'b01);
    wait_valid("t3_valid");
    chk("t3_latency", 32'(cyc - t0), 32'd4);
    held = {16'(t0 + 3), 1'b0, 1'b1};
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("t3_hold_vld%0d", i), 32'(evt_valid_o), 32'd1);
      chk($sformatf("t3_hold_data%0d", i), 32'(evt_data_o), 32'(held));
      @(negedge clk);
    end
    evt_ready_i = 1'b1;
    chk("t3_vld_c11", 32'(evt_valid_o), 32'd1);
    @(negedge clk);
    chk("t3_vld_after", 32'(evt_valid_o), 32'd0);
    chk("t3_ref_after", 32'(arb_refresh_o), 32'd1);
    @(negedge clk);

    // Three drops on pending row 0; packet keeps the first polarity.
    en_i = 1'b0;
    pulse(2'b01, 2'b01);
    event_i = 2'b01; pol_i = 2'b00;
    repeat (3) @(negedge clk);
    event_i = 2'b00;
    @(negedge clk);
    chk("t4_drop3", 32'(drop_cnt_o), 32'd3);
    chk("t4_req", 32'(req_o), 32'b01);
    chk("t4_no_en", 32'(arb_enable_o), 32'd0);
    en_i = 1'b1;
    pkts.delete(); nref = 0; nref_late = 0;
    run_collect(8);
    chk("t4_npkts", 32'(pkts.size()), 32'd1);
    if (pkts.size() == 1) chk("t4_pkt_rowpol", 32'(pkts[0][1:0]), 32'b01);

    // Event on row 1 in its own CAPTURE cycle: set wins, second packet follows.
    t0 = cyc;
    pulse(2'b10, 2'b10);
    repeat (2) @(negedge clk);
    event_i = 2'b10; pol_i = 2'b00;
    @(negedge clk);
    event_i = 2'b00;
    pkts.delete(); nref = 0; nref_late = 0;
    run_collect(10);
    chk("t5_npkts", 32'(pkts.size()), 32'd2);
    if (pkts.size() == 2) begin
      chk("t5_p0", 32'(pkts[0]), 32'({16'(t0 + 3), 1'b1, 1'b1}));
      chk("t5_p1", 32'(pkts[1]), 32'({16'(t0 + 8), 1'b1, 1'b0}));
    end
    chk("t5_drop", 32'(drop_cnt_o), 32'd3);
    chk("t5_nref", 32'(nref), 32'd2);

    // Simultaneous drops add popcount, then saturation at 255.
    en_i = 1'b0;
    pulse(2'b11, 2'b11);
    pulse(2'b11, 2'b00);
    chk("t4_drop_pair", 32'(drop_cnt_o), 32'd5);
    event_i = 2'b01;
    repeat (300) @(negedge clk);
    event_i = 2'b00;
    @(negedge clk);
    chk("t4_drop_sat", 32'(drop_cnt_o), 32'd255);

    // Reset asserted in SEND clears outputs without waiting for a clock.
    evt_ready_i = 1'b0;
    en_i = 1'b1;
    wait_valid("t6_valid");
    chk("t6_req_pre", 32'(req_o), 32'b10);
    chk("t6_data_pre", 32'(evt_data_o[1:0]), 32'b01);
    #2 reset_i = 1'b1;
    #1;
    chk("t6_vld_rst", 32'(evt_valid_o), 32'd0);
    chk("t6_req_rst", 32'(req_o), 32'd0);
    chk("t6_drop_rst", 32'(drop_cnt_o), 32'd0);
    @(negedge clk);
    reset_i = 1'b0;
    en_i = 1'b0;
    evt_ready_i = 1'b1;
    pulse(2'b01, 2'b00);
    nen = 0;
    for (int i = 0; i < 10; i++) begin
      if (arb_enable_o) nen++;
      @(negedge clk);
    end
    chk("t6_req_noen", 32'(req_o), 32'b01);
    chk("t6_no_enable", 32'(nen), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/row_event_readout.md
# row_event_readout

Requester/consumer side of the row arbitration handshake in the pixel-block hierarchy. Latches per-row pixel events into pending requests and presents them to the row arbiter. It sequences the arbiter's enable/refresh controls and captures the registered one-hot grant and encoded row address. Each serviced event is emitted as a timestamped packet over a valid/ready stream toward the next hierarchy level.

## Interface
Parameters:
- LVL_ROWS, 2, number of rows served (arbiter request width)
- LVL_ROW_ADD, 1, encoded row address width (clog2 of LVL_ROWS, min 1)
- TS_WIDTH, 16, free-running timestamp width

Ports:
- clk_i  in  1  clock
- reset_i  in  1  reset, asynchronous, active-high
- en_i  in  1  readout enable; low stops new grant cycles
- event_i  in  LVL_ROWS  per-row event pulse, one cycle per event
- pol_i  in  LVL_ROWS  per-row polarity, sampled with event_i
- req_o  out  LVL_ROWS  pending requests to arbiter (registered)
- arb_enable_o  out  1  arbiter enable, one-cycle pulse
- arb_refresh_o  out  1  arbiter refresh, one-cycle pulse
- gnt_i  in  LVL_ROWS  arbiter registered one-hot grant
- xadd_i  in  LVL_ROW_ADD  arbiter encoded granted row
- grp_release_i  in  1  arbiter: no masked requests remain
- evt_valid_o  out  1  packet valid
- evt_ready_i  in  1  downstream ready
- evt_data_o  out  TS_WIDTH+LVL_ROW_ADD+1  {timestamp, row address, polarity}
- drop_cnt_o  out  8  saturating count of dropped events

## Operation
- Reset: pending, polarity regs, req_o, arb_enable_o, arb_refresh_o, evt_valid_o, evt_data_o, drop_cnt_o, timestamp all 0; FSM in IDLE.
- Timestamp: increments every cycle after reset and wraps modulo 2^TS_WIDTH. Runs regardless of en_i.
- Pending set: event_i[r]=1 sets pending[r] and latches pol_i[r].
- Drop: event_i[r]=1 while pending[r]=1 and the row is not being cleared this cycle. The event is discarded, polarity is unchanged, and drop_cnt_o increments, saturating at 255. Multiple simultaneous drops in one cycle add their popcount, saturating.
- Pending clear: the CAPTURE state clears pending[r] for the granted row. If event_i[r] arrives in the same cycle, set wins: the row stays pending with the new polarity and no drop is counted.
- req_o equals pending.
- FSM states:
  - IDLE: if en_i and |pending, go to GRANT.
  - GRANT: arb_enable_o=1, go to CAPTURE.
  - CAPTURE: if gnt_i is nonzero, load evt_data_o = {timestamp, xadd_i, pol[xadd_i]}, clear pending[xadd_i], and go to SEND. If gnt_i is zero (spurious), go to REFRESH with no packet.
  - SEND: evt_valid_o=1. On evt_valid_o && evt_ready_i, go to REFRESH if grp_release_i, else IDLE.
  - REFRESH: arb_refresh_o=1 (arb_enable_o=0 here, so refresh is honored), go to IDLE.
- arb_enable_o and arb_refresh_o are never high together.
- evt_data_o is held stable while evt_valid_o=1 and not accepted. evt_valid_o does not drop until the handshake completes.
- en_i deasserted mid-cycle: the current GRANT/CAPTURE/SEND/REFRESH sequence completes, then the FSM stays in IDLE. Pending bits keep accumulating.
- Reset mid-operation: all state returns to its reset value immediately. Any in-flight packet is lost.

## Timing
- Event pulse in cycle t: pending and req_o are visible in cycle t+1.
- With the FSM idle, event in cycle t gives:
  - GRANT (arb_enable_o=1) in t+2
  - CAPTURE in t+3, with gnt_i/xadd_i valid from the arbiter's registered output
  - evt_valid_o in t+4
- Minimum service interval is 4 cycles per event, or 5 when a refresh follows.
- The timestamp in a packet equals the counter value in the CAPTURE cycle.
- grp_release_i is sampled only in the SEND handshake cycle, after the granted pending bit has cleared.

## Test plan
- Reset release at cycle 0, event_i=2'b10, pol_i=2'b10 in cycle 0:
  - req_o=2'b10 at cycle 1, arb_enable_o at cycle 2
  - evt_valid_o at cycle 4 with data {ts=3, xadd=1, pol=1}
  - arb_refresh_o at cycle 5 after ready, since no masked requests remain
- Events on both rows together (event_i=2'b11) with evt_ready_i=1: packets are emitted for row 0 then row 1, each with a distinct increasing ts. Exactly one arb_refresh_o pulse follows the second packet.
- evt_ready_i held low 10 cycles in SEND: evt_valid_o stays 1 and evt_data_o is unchanged. Accept on cycle 11 leads to the next state.
- Repeat event on pending row 0 three times: drop_cnt_o=3 and the packet carries the first polarity. Then 300 drops: drop_cnt_o saturates at 255.
- Event on row 1 in its own CAPTURE cycle: no drop counted, row 1 re-requests, and a second packet follows with the new polarity.
- Assert reset_i while in SEND: evt_valid_o, req_o and drop_cnt_o go to 0 asynchronously. With en_i=0, new events set req_o but no arb_enable_o pulse occurs.
